// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch side of the MIPS core: memory map,
// the nop encoding and the IF/ID pipeline-register layout.
package cpu_defs;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam int unsigned IMEM_WORDS = 4096;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } if_id_t;

    // True when a fetch from addr would be misaligned or outside instruction memory.
    function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned words);
        logic [31:0] last;
        last = base + 32'(words * 4) - 32'd4;
        return (addr[1:0] != 2'b00) || (addr < base) || (addr > last);
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with stall/redirect/increment selection and the
// fetch-address legality decode for the current PC.
module pc_reg #(
    parameter logic [31:0] PC_RESET   = cpu_defs::PC_RESET,
    parameter logic [31:0] IMEM_BASE  = cpu_defs::IMEM_BASE,
    parameter int unsigned IMEM_WORDS = cpu_defs::IMEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        bad_addr
);
    import cpu_defs::*;

    logic [31:0] pc_reg_q;
    logic [31:0] pc_next;

    // A stalled redirect is dropped; decode holds it until the stall clears.
    always_comb begin
        pc_next = pc_reg_q + 32'd4;
        if (stall) begin
            pc_next = pc_reg_q;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg_q <= PC_RESET;
        end else begin
            pc_reg_q <= pc_next;
        end
    end

    assign pc       = pc_reg_q;
    assign bad_addr = fetch_addr_bad(pc_reg_q, IMEM_BASE, IMEM_WORDS);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the imem address from the PC and loads
// the IF/ID register, honouring flush over stall; redirect keeps the delay slot.
module if_stage #(
    parameter logic [31:0] PC_RESET   = cpu_defs::PC_RESET,
    parameter logic [31:0] IMEM_BASE  = cpu_defs::IMEM_BASE,
    parameter int unsigned IMEM_WORDS = cpu_defs::IMEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic        D_valid,
    output logic        D_adel,
    output logic [31:0] fetch_count
);
    import cpu_defs::*;

    logic        bad_addr;
    if_id_t      if_id_reg;
    if_id_t      if_id_next;
    logic [31:0] fetch_count_reg;
    logic [31:0] fetch_count_next;

    pc_reg #(
        .PC_RESET   (PC_RESET),
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (F_pc),
        .bad_addr    (bad_addr)
    );

    assign imem_addr = F_pc;

    // Flush beats stall; a bubble still records the PC it replaced.
    always_comb begin
        if_id_next       = if_id_reg;
        fetch_count_next = fetch_count_reg;
        if (flush) begin
            if_id_next.instr = NOP;
            if_id_next.pc    = F_pc;
            if_id_next.valid = 1'b0;
            if_id_next.adel  = 1'b0;
        end else if (!stall) begin
            if_id_next.instr = bad_addr ? NOP : imem_rdata;
            if_id_next.pc    = F_pc;
            if_id_next.valid = 1'b1;
            if_id_next.adel  = bad_addr;
            fetch_count_next = fetch_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_reg       <= '0;
            fetch_count_reg <= '0;
        end else begin
            if_id_reg       <= if_id_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    assign D_instr     = if_id_reg.instr;
    assign D_pc        = if_id_reg.pc;
    assign D_valid     = if_id_reg.valid;
    assign D_adel      = if_id_reg.adel;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async-reset check, then
// randomized traffic against a behavioural model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] C_WORD = 32'h2408_0001;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam logic [31:0] LAST   = 32'h0000_3000 + 32'd4 * 32'd4096 - 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect, flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] F_pc, D_instr, D_pc, fetch_count;
    logic        D_valid, D_adel;
    logic        imem_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] hash_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = imem_mode ? hash_word(imem_addr) : C_WORD;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .F_pc        (F_pc),
        .D_instr     (D_instr),
        .D_pc        (D_pc),
        .D_valid     (D_valid),
        .D_adel      (D_adel),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_fpc, input logic [31:0] e_instr,
                           input logic [31:0] e_dpc, input logic e_valid, input logic e_adel,
                           input logic [31:0] e_cnt);
        chk({tag, " F_pc"}, F_pc, e_fpc);
        chk({tag, " imem_addr"}, imem_addr, e_fpc);
        chk({tag, " D_instr"}, D_instr, e_instr);
        chk({tag, " D_pc"}, D_pc, e_dpc);
        chk({tag, " D_valid"}, {31'd0, D_valid}, {31'd0, e_valid});
        chk({tag, " D_adel"}, {31'd0, D_adel}, {31'd0, e_adel});
        chk({tag, " fetch_count"}, fetch_count, e_cnt);
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        fl;
        logic [31:0] e_fpc;
        logic [31:0] e_instr;
        logic [31:0] e_dpc;
        logic        e_valid;
        logic        e_adel;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[25];

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_dpc, m_cnt;
    logic        m_valid, m_adel;

    task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc, input logic fl);
        logic        addr_bad;
        logic [31:0] word;
        addr_bad = (m_pc % 4 != 0) || (m_pc < BASE) || (m_pc > LAST);
        word     = imem_mode ? hash_word(m_pc) : C_WORD;
        if (fl) begin
            m_instr = 0; m_valid = 0; m_adel = 0; m_dpc = m_pc;
        end else if (!st) begin
            m_instr = addr_bad ? 32'd0 : word;
            m_dpc   = m_pc;
            m_valid = 1;
            m_adel  = addr_bad;
            m_cnt   = m_cnt + 1;
        end
        if (!st) m_pc = rd ? rpc : m_pc + 4;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic fl);
        stall = st; redirect = rd; redirect_pc = rpc; flush = fl;
    endtask

    initial begin
        reset = 1'b1;
        imem_mode = 1'b0;
        drive(0, 0, 32'd0, 0);

        //        st rd rpc          fl  F_pc        D_instr  D_pc        v  adel cnt
        vecs[0]  = '{0, 0, 32'h0,     0, 32'h3004, C_WORD, 32'h3000, 1, 0, 1};
        vecs[1]  = '{0, 0, 32'h0,     0, 32'h3008, C_WORD, 32'h3004, 1, 0, 2};
        vecs[2]  = '{1, 0, 32'h0,     0, 32'h3008, C_WORD, 32'h3004, 1, 0, 2};
        vecs[3]  = '{1, 0, 32'h0,     0, 32'h3008, C_WORD, 32'h3004, 1, 0, 2};
        vecs[4]  = '{0, 0, 32'h0,     0, 32'h300C, C_WORD, 32'h3008, 1, 0, 3};
        vecs[5]  = '{0, 0, 32'h0,     0, 32'h3010, C_WORD, 32'h300C, 1, 0, 4};
        vecs[6]  = '{0, 1, 32'h3100,  0, 32'h3100, C_WORD, 32'h3010, 1, 0, 5};
        vecs[7]  = '{0, 0, 32'h0,     0, 32'h3104, C_WORD, 32'h3100, 1, 0, 6};
        vecs[8]  = '{1, 1, 32'h3200,  0, 32'h3104, C_WORD, 32'h3100, 1, 0, 6};
        vecs[9]  = '{0, 1, 32'h3200,  0, 32'h3200, C_WORD, 32'h3104, 1, 0, 7};
        vecs[10] = '{0, 1, 32'h3102,  0, 32'h3102, C_WORD, 32'h3200, 1, 0, 8};
        vecs[11] = '{0, 0, 32'h0,     0, 32'h3106, 32'h0,  32'h3102, 1, 1, 9};
        vecs[12] = '{0, 0, 32'h0,     0, 32'h310A, 32'h0,  32'h3106, 1, 1, 10};
        vecs[13] = '{0, 1, 32'h3300,  0, 32'h3300, 32'h0,  32'h310A, 1, 1, 11};
        vecs[14] = '{0, 0, 32'h0,     1, 32'h3304, 32'h0,  32'h3300, 0, 0, 11};
        vecs[15] = '{1, 1, 32'h3400,  1, 32'h3304, 32'h0,  32'h3304, 0, 0, 11};
        vecs[16] = '{0, 0, 32'h0,     0, 32'h3308, C_WORD, 32'h3304, 1, 0, 12};
        vecs[17] = '{0, 1, 32'h6FFC,  0, 32'h6FFC, C_WORD, 32'h3308, 1, 0, 13};
        vecs[18] = '{0, 0, 32'h0,     0, 32'h7000, C_WORD, 32'h6FFC, 1, 0, 14};
        vecs[19] = '{0, 0, 32'h0,     0, 32'h7004, 32'h0,  32'h7000, 1, 1, 15};
        vecs[20] = '{0, 1, 32'h2FFC,  0, 32'h2FFC, 32'h0,  32'h7004, 1, 1, 16};
        vecs[21] = '{0, 0, 32'h0,     0, 32'h3000, 32'h0,  32'h2FFC, 1, 1, 17};
        vecs[22] = '{0, 0, 32'h0,     0, 32'h3004, C_WORD, 32'h3000, 1, 0, 18};
        vecs[23] = '{0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, C_WORD, 32'h3004, 1, 0, 19};
        vecs[24] = '{0, 0, 32'h0,     0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 1, 1, 20};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_hold", 32'h3000, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].fl);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_fpc, vecs[i].e_instr, vecs[i].e_dpc,
                    vecs[i].e_valid, vecs[i].e_adel, vecs[i].e_cnt);
            $display("vec %0d: st=%0d rd=%0d rpc=%h fl=%0d -> F_pc=%h D_pc=%h D_instr=%h v=%0d adel=%0d cnt=%0d",
                     i, vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].fl,
                     F_pc, D_pc, D_instr, D_valid, D_adel, fetch_count);
        end

        // Asynchronous reset in the middle of a cycle
        drive(0, 1, 32'h3040, 0);
        @(posedge clk);
        #1;
        chk("pre_async F_pc", F_pc, 32'h3040);
        drive(0, 0, 32'h0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 32'h3000, 32'h0, 32'h0, 0, 0, 32'h0);
        $display("async reset mid-cycle: F_pc=%h D_valid=%0d cnt=%0d", F_pc, D_valid, fetch_count);
        drive(0, 1, 32'h3500, 0);
        @(posedge clk);
        #1;
        chk_all("reset_over_edge", 32'h3000, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0);
        reset = 1'b0;

        // Randomized traffic against the model
        imem_mode = 1'b1;
        m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_cnt = 0; m_valid = 0; m_adel = 0;
        for (int n = 0; n < 200; n++) begin
            logic        st, rd, fl;
            logic [31:0] rpc;
            int          sel;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)       rpc = BASE + 32'd4 * 32'($urandom_range(0, 4095));
            else if (sel == 6) rpc = BASE + 32'd4 * 32'($urandom_range(0, 4095)) + 32'($urandom_range(1, 3));
            else if (sel == 7) rpc = ($urandom_range(0, 1) == 0) ? LAST : LAST + 32'd4;
            else if (sel == 8) rpc = BASE - 32'd4;
            else               rpc = $urandom;
            drive(st, rd, rpc, fl);
            model_edge(st, rd, rpc, fl);
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", n), m_pc, m_instr, m_dpc, m_valid, m_adel, m_cnt);
            $display("rnd %0d: st=%0d rd=%0d rpc=%h fl=%0d -> F_pc=%h D_pc=%h v=%0d adel=%0d cnt=%0d",
                     n, st, rd, rpc, fl, F_pc, D_pc, D_valid, D_adel, fetch_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage pipelined MIPS core, immediately upstream of decode.
- Owns the program counter and drives the instruction-memory address.
- Captures the fetched word into the IF/ID pipeline register, applying stall, redirect and flush from downstream.
- Architectural branch delay slot: a taken redirect never squashes the already-fetched delay-slot instruction.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, instruction-memory depth in 32-bit words; legal range is IMEM_BASE .. IMEM_BASE+4*IMEM_WORDS-4.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  from hazard unit; hold PC and IF/ID this cycle.
- redirect  in  1  from decode; taken branch or jump.
- redirect_pc  in  32  target of redirect.
- flush  in  1  clear IF/ID to a bubble.
- imem_addr  out  32  combinational fetch address (equals F_pc).
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- F_pc  out  32  current PC register.
- D_instr  out  32  IF/ID instruction.
- D_pc  out  32  IF/ID PC.
- D_valid  out  1  IF/ID holds a real instruction, not a bubble.
- D_adel  out  1  IF/ID fetch-address error flag.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- On reset assertion:
  - F_pc = PC_RESET.
  - D_instr = 0, D_pc = 0, D_valid = 0, D_adel = 0, fetch_count = 0.
  - Takes effect without waiting for clk.
  - Reset wins over every other input on any edge; state holds reset values while reset is high.
- Fetch is single-cycle: imem_addr = F_pc. The word appears in D_instr one edge later (latency 1).
- PC next-state, priority high to low:
  1. stall=1: hold F_pc. Redirect is ignored; decode re-asserts it after the stall clears.
  2. redirect=1: F_pc <= redirect_pc.
  3. otherwise: F_pc <= F_pc + 4, 32-bit wrap.
- IF/ID next-state, priority high to low:
  1. flush=1:
     - D_instr = 0, D_valid = 0, D_adel = 0; D_pc <= F_pc.
     - Applies even when stall=1.
  2. stall=1: hold all IF/ID fields.
  3. otherwise: D_instr <= imem_rdata, D_pc <= F_pc, D_valid <= 1, D_adel <= bad_addr.
- redirect alone never clears IF/ID. The instruction fetched on the redirect cycle is the delay slot and is kept.
- bad_addr = 1 when any of these holds:
  - F_pc[1:0] != 0;
  - F_pc < IMEM_BASE;
  - F_pc > IMEM_BASE + 4*IMEM_WORDS - 4.
- When bad_addr=1:
  - D_instr <= 0 (nop), D_adel <= 1, D_valid <= 1.
  - The PC still advances normally. Exception handling is downstream.
- fetch_count increments by 1 on each edge where IF/ID loads with D_valid becoming 1 (no stall, no flush). It wraps at 2^32.
- Simultaneous stall+redirect+flush: PC holds, IF/ID becomes a bubble.

Decomposition:
- Shared package cpu_defs holds:
  - PC_RESET, IMEM_BASE, IMEM_WORDS;
  - NOP = 32'h0;
  - a struct if_id_t {instr, pc, valid, adel}.
- One natural sub-module: pc_reg. It holds the PC with async reset and the stall/redirect/increment mux, plus bad_addr decode.
- The IF/ID register and fetch_count stay in if_stage.

Test Plan:
- Reset then release, imem returns 32'h2408_0001 at every address:
  - F_pc steps 3000, 3004, 3008.
  - D_pc lags by one cycle.
  - D_valid rises one cycle after release; fetch_count = 3 after three free edges.
- stall=1 for 2 cycles at F_pc=3008: F_pc, D_pc and D_instr hold for both cycles, fetch_count unchanged; the sequence resumes at 300C.
- redirect=1 with redirect_pc=3100 while F_pc=3010:
  - next F_pc = 3100;
  - D_pc = 3010 with valid=1 (delay slot preserved);
  - the following D_pc = 3100.
- stall=1 and redirect=1 together (redirect_pc=3200): F_pc holds. Next cycle redirect=1 with stall=0 gives F_pc = 3200.
- redirect_pc = 3102 (misaligned):
  - the next IF/ID load has D_adel=1, D_instr=0, D_pc=3102;
  - F_pc then becomes 3106.
- Reset asserted mid-clock while F_pc=3040: F_pc = 3000 and D_valid = 0 immediately, before the next edge.
